// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the sequence detector and its serializer feeder.
package seq_det_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } ser_state_e;

    localparam int unsigned SEQ_WORD_W     = 8;
    localparam int unsigned SEQ_FIFO_DEPTH = 4;

    // Width of a down-counter that must hold n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    // Width of an occupancy counter that must hold 0..depth inclusive.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

endpackage

// File: rtl/seq_ser_fifo.sv
// Synchronous word FIFO for the serializer; power-of-2 depth with masked pointer wrap.
module seq_ser_fifo
    import seq_det_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WORD_W,
    parameter int unsigned DEPTH = SEQ_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = lvl_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q + PTR_W'(1)) & PTR_MASK;
            if (pop)  rd_ptr_q <= (rd_ptr_q + PTR_W'(1)) & PTR_MASK;
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // Storage needs no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/seq_serializer.sv
// Word-to-bit serializer feeding the sequence detector; back-to-back words, no gap bits.
// Define SEQ_SER_LSB_FIRST_EN to shift words LSB-first (default MSB-first).
module seq_serializer
    import seq_det_pkg::*;
#(
    parameter int unsigned WORD_W     = SEQ_WORD_W,
    parameter int unsigned FIFO_DEPTH = SEQ_FIFO_DEPTH,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          word_valid,
    output logic                          word_ready,
    input  logic [WORD_W-1:0]             word_data,
    output logic                          seq_out,
    output logic                          seq_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned CNT_W = cnt_w(WORD_W);
    localparam int unsigned LVL_W = lvl_w(FIFO_DEPTH);

    ser_state_e        state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              seq_out_q, seq_out_d;
    logic              seq_valid_q, seq_valid_d;

    logic              push, pop, load;
    logic              fifo_full, fifo_empty;
    logic [WORD_W-1:0] head;
    logic [LVL_W-1:0]  fifo_level;

    logic              load_bit, shift_bit;
    logic [WORD_W-1:0] load_shreg, shift_shreg;

    assign word_ready = !rst && !fifo_full;
    assign push       = word_valid && word_ready;

    seq_ser_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (word_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef SEQ_SER_LSB_FIRST_EN
    assign load_bit    = head[0];
    assign load_shreg  = {1'b0, head[WORD_W-1:1]};
    assign shift_bit   = shreg_q[0];
    assign shift_shreg = {1'b0, shreg_q[WORD_W-1:1]};
`else
    assign load_bit    = head[WORD_W-1];
    assign load_shreg  = {head[WORD_W-2:0], 1'b0};
    assign shift_bit   = shreg_q[WORD_W-1];
    assign shift_shreg = {shreg_q[WORD_W-2:0], 1'b0};
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        seq_out_d   = IDLE_LEVEL;
        seq_valid_d = 1'b0;
        pop         = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    seq_out_d   = shift_bit;
                    seq_valid_d = 1'b1;
                    shreg_d     = shift_shreg;
                    bit_cnt_d   = bit_cnt_q - CNT_W'(1);
                end else if (!fifo_empty) begin
                    // Last bit of a word is on the wire: chain the next one with no gap.
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            pop         = 1'b1;
            seq_out_d   = load_bit;
            seq_valid_d = 1'b1;
            shreg_d     = load_shreg;
            bit_cnt_d   = CNT_W'(WORD_W - 1);
            state_d     = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            seq_out_q   <= IDLE_LEVEL;
            seq_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            seq_out_q   <= seq_out_d;
            seq_valid_q <= seq_valid_d;
        end
    end

    assign seq_out   = seq_out_q;
    assign seq_valid = seq_valid_q;
    assign busy      = (state_q == SHIFT) || (fifo_level != '0);
    assign level     = fifo_level;

endmodule
